// File: rtl/mips_data_bus_master_if.sv
// Avalon-style data bus between mips_data_bus_master and the data RAM / bus slave.
interface mips_data_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              write;
  logic              read;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, byteenable, write, read, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, byteenable, write, read, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mips_data_bus_master.sv
// Load/store bus master: one request at a time, word-aligned bus cycles, load extension.
// Optional MISALIGN_TRAP_EN: misaligned requests skip the bus and respond with resp_err=1.
module mips_data_bus_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  mips_data_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} state_t;

  state_t            state, state_d;
  logic              read_q, read_d, write_q, write_d;
  logic              we_q, signed_q;
  logic [1:0]        size_q, lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be_req;
  logic [31:0]       wd_q, wd_req, rdata_q, load_ext;
  logic              accept, trap;

  assign accept = req_valid && (state == IDLE);

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign trap = ((req_size == 2'b01) && req_addr[0]) ||
                (req_size[1] && (req_addr[1:0] != 2'b00));
  assign resp_err = err_q;
`else
  assign trap     = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    be_req = 4'b1111;
    wd_req = req_wdata;
    case (req_size)
      2'b00: begin
        be_req = 4'b0001 << req_addr[1:0];
        wd_req = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_req = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_req = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = bus.readdata[7:0];
    case (lo_q)
      2'b01:   b = bus.readdata[15:8];
      2'b10:   b = bus.readdata[23:16];
      2'b11:   b = bus.readdata[31:24];
      default: ;
    endcase
    h = lo_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & b[7]}}, b};
      2'b01:   load_ext = {{16{signed_q & h[15]}}, h};
      default: load_ext = bus.readdata;
    endcase
  end

  always_comb begin
    state_d = state;
    read_d  = read_q;
    write_d = write_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (trap) begin
            state_d = RESP;
          end else begin
            state_d = ISSUE;
            read_d  = !req_we;
            write_d = req_we;
          end
        end
      end
      ISSUE: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = we_q ? RESP : RDATA;
        end
      end
      RDATA:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state   <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      be_q     <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
        err_q   <= trap;
`endif
        // Trapped requests leave the bus registers untouched: no bus cycle is issued.
        if (!trap) begin
          addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
          be_q     <= be_req;
          wd_q     <= wd_req;
          we_q     <= req_we;
          signed_q <= req_signed;
          size_q   <= req_size;
          lo_q     <= req_addr[1:0];
        end
      end
      if (state == RDATA) rdata_q <= load_ext;
    end
  end

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_rdata     = rdata_q;
  assign bus.address    = addr_q;
  assign bus.byteenable = be_q;
  assign bus.writedata  = wd_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;

endmodule

// File: tb/tb_mips_data_bus_master.sv
// Directed self-checking bench for mips_data_bus_master.
module tb_mips_data_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          errors = 0;
  int          checks = 0;

  mips_data_bus_master_if #(.ADDR_W(32)) bus ();

  mips_data_bus_master #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE; returns 1 ns after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        bus.read !== 1'b0 || bus.write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b rv=%b err=%b rd=%b wr=%b, want 1 0 0 0 0",
               req_ready, resp_valid, resp_err, bus.read, bus.write);
    end
    checks++;
    if (bus.address !== 32'h0 || bus.byteenable !== 4'h0 || bus.writedata !== 32'h0 ||
        resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h be=%b wd=%h rdata=%h, want all 0",
               bus.address, bus.byteenable, bus.writedata, resp_rdata);
    end
  endtask

  task automatic test_store_word();
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++;
    if (bus.write !== 1'b1 || bus.read !== 1'b0 || bus.byteenable !== 4'b1111 ||
        bus.address !== 32'h10 || bus.writedata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_issue: wr=%b rd=%b be=%b addr=%h wd=%h, want 1 0 1111 10 deadbeef",
               bus.write, bus.read, bus.byteenable, bus.address, bus.writedata);
    end
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_busy: ready=%b rv=%b, want 0 0", req_ready, resp_valid);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || bus.write !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_resp: rv=%b wr=%b rdata=%h err=%b, want 1 0 0 0",
               resp_valid, bus.write, resp_rdata, resp_err);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL sw_done: rv=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
  endtask

  // Load with no stall; checks strobe, lanes and extended result.
  task automatic do_load(input string name, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    bus.readdata = rdata;
    issue(1'b0, size, sgn, addr, 32'h0);
    checks++;
    if (bus.read !== 1'b1 || bus.write !== 1'b0 || bus.byteenable !== exp_be ||
        bus.address !== exp_addr) begin
      errors++;
      $display("FAIL %s_issue: rd=%b wr=%b be=%b addr=%h, want 1 0 %b %h",
               name, bus.read, bus.write, bus.byteenable, bus.address, exp_be, exp_addr);
    end
    step();
    checks++;
    if (bus.read !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_rdata: rd=%b rv=%b, want 0 0", name, bus.read, resp_valid);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== exp_data || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp: rv=%b rdata=%h err=%b, want 1 %h 0",
               name, resp_valid, resp_rdata, resp_err, exp_data);
    end
    step();
  endtask

  task automatic test_load_byte();
    do_load("lb",   2'b00, 1'b1, 32'h13, 32'h80FF7F01, 4'b1000, 32'h10, 32'hFFFFFF80);
    do_load("lbu",  2'b00, 1'b0, 32'h13, 32'h80FF7F01, 4'b1000, 32'h10, 32'h00000080);
    do_load("lb1",  2'b00, 1'b1, 32'h11, 32'h80FF7F01, 4'b0010, 32'h10, 32'h0000007F);
    do_load("lbu2", 2'b00, 1'b0, 32'h12, 32'h80FF7F01, 4'b0100, 32'h10, 32'h000000FF);
  endtask

  task automatic test_half();
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD);
    checks++;
    if (bus.write !== 1'b1 || bus.byteenable !== 4'b1100 || bus.writedata !== 32'hABCDABCD ||
        bus.address !== 32'h20) begin
      errors++;
      $display("FAIL sh_issue: wr=%b be=%b wd=%h addr=%h, want 1 1100 abcdabcd 20",
               bus.write, bus.byteenable, bus.writedata, bus.address);
    end
    step();
    step();
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AB);
    checks++;
    if (bus.byteenable !== 4'b0100 || bus.writedata !== 32'hABABABAB) begin
      errors++;
      $display("FAIL sb_issue: be=%b wd=%h, want 0100 abababab", bus.byteenable, bus.writedata);
    end
    step();
    step();
    do_load("lh",  2'b01, 1'b1, 32'h22, 32'h80011234, 4'b1100, 32'h20, 32'hFFFF8001);
    do_load("lhu", 2'b01, 1'b0, 32'h20, 32'h8001F234, 4'b0011, 32'h20, 32'h0000F234);
    do_load("lw3", 2'b11, 1'b0, 32'h30, 32'hCAFEF00D, 4'b1111, 32'h30, 32'hCAFEF00D);
  endtask

  task automatic test_wait_stall();
    bus.readdata    = 32'h12345678;
    bus.waitrequest = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    // A competing store during the stall must be ignored.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h80;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (i == 4) bus.waitrequest = 1'b0;
      checks++;
      if (bus.read !== 1'b1 || bus.write !== 1'b0 || bus.address !== 32'h40 ||
          req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_c%0d: rd=%b wr=%b addr=%h ready=%b rv=%b, want 1 0 40 0 0",
                 i, bus.read, bus.write, bus.address, req_ready, resp_valid);
      end
      step();
    end
    checks++;
    if (bus.read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_c5: rd=%b rv=%b ready=%b, want 0 0 0", bus.read, resp_valid, req_ready);
    end
    req_valid = 1'b0;
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL stall_resp: rv=%b rdata=%h, want 1 12345678", resp_valid, resp_rdata);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bus.write !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: rv=%b ready=%b wr=%b, want 0 1 0", resp_valid, req_ready, bus.write);
    end
  endtask

  task automatic test_misaligned();
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h05, 32'h0);
    checks++;
    if (bus.read !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL lw_trap: rd=%b rv=%b err=%b rdata=%h, want 0 1 1 0",
               bus.read, resp_valid, resp_err, resp_rdata);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lw_trap_done: rv=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
`else
    do_load("lw_mis", 2'b10, 1'b0, 32'h05, 32'hA5A55A5A, 4'b1111, 32'h04, 32'hA5A55A5A);
    do_load("lh_mis", 2'b01, 1'b1, 32'h23, 32'h9000000F, 4'b1100, 32'h20, 32'hFFFF9000);
`endif
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    bus.waitrequest = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    checks++;
    if (bus.read !== 1'b1) begin
      errors++;
      $display("FAIL rmid_issue: rd=%b, want 1", bus.read);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.read !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset: rd=%b ready=%b rv=%b, want 0 1 0", bus.read, req_ready, resp_valid);
    end
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (resp_valid === 1'b1 || bus.read === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rmid_quiet: %0d cycles with resp_valid/read high, want 0", pulses);
    end
  endtask

  initial begin
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_we          = 1'b0;
    req_size        = 2'b00;
    req_signed      = 1'b0;
    req_addr        = 32'h0;
    req_wdata       = 32'h0;
    bus.readdata    = 32'h0;
    bus.waitrequest = 1'b0;
    #1;
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_wait_stall();
    test_misaligned();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
